// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
//  Package : lc3_pkg
//  Brief   : Shared LC-3 datapath constants and the fetch sequencer state type.
//  Rev     : 1.0  initial release
// ============================================================================
package lc3_pkg;

    // PC register source select, shared with the PC register mux
    localparam logic [1:0] PC_MUX_INC = 2'b00;
    localparam logic [1:0] PC_MUX_BUS = 2'b01;
    localparam logic [1:0] PC_MUX_JMP = 2'b10;

    // Instruction-fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/lc3_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : lc3_fetch_unit_if
//  Brief     : Instruction-memory read bus between the fetch unit (master)
//              and instruction memory (slave).
//  Rev       : 1.0  initial release
// ============================================================================
interface lc3_fetch_unit_if;

    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ready,
        output mem_rdata
    );

endinterface : lc3_fetch_unit_if
`default_nettype wire

// File: rtl/lc3_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : lc3_fetch_unit
//  Brief  : LC-3 instruction-fetch sequencer. Latches the PC, runs a read
//           handshake with instruction memory (wait states, bounded timeout,
//           flush), loads the instruction register and requests PC+1.
//  Rev    : 1.0  initial release
// ============================================================================
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        fetch_req,
    input  wire logic        flush,
    input  wire logic [15:0] pc_in,
    lc3_fetch_unit_if.master mem,
    output logic             ld_pc,
    output logic [1:0]       pc_mux,
    output logic [15:0]      ir,
    output logic [15:0]      ir_pc,
    output logic             ir_valid,
    output logic             busy,
    output logic             fetch_err
);

    // Counter value reached in the final permitted RD cycle
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    fetch_state_t r_state;
    fetch_state_t w_next_state;
    logic [15:0]  r_addr_q;
    logic [15:0]  r_cnt;
    logic [15:0]  r_ir;
    logic [15:0]  r_ir_pc;

    logic w_capture;
    logic w_load_ir;
    logic w_cnt_inc;
    logic w_mem_rd;
    logic w_ld_pc;
    logic w_ir_valid;
    logic w_fetch_err;

    // State register; async reset drops the read request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-cycle strobes; flush outranks everything in RD
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load_ir    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_mem_rd     = 1'b0;
        w_ld_pc      = 1'b0;
        w_ir_valid   = 1'b0;
        w_fetch_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req && !flush) begin
                    w_capture    = 1'b1;
                    w_next_state = RD;
                end
            end
            RD: begin
                w_mem_rd = !flush;
                if (flush) begin
                    w_next_state = IDLE;
                end else if (mem.mem_ready) begin
                    w_load_ir    = 1'b1;
                    w_ld_pc      = 1'b1;
                    w_next_state = DONE;
                end else if (r_cnt == c_timeout_last) begin
                    w_fetch_err  = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DONE: begin
                w_ir_valid = !flush;
                if (fetch_req && !flush) begin
                    // pc_in has already been advanced by the ld_pc of the previous RD
                    w_capture    = 1'b1;
                    w_next_state = RD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request address and timeout counter; counter saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_q <= 16'h0000;
            r_cnt    <= 16'h0000;
        end else if (w_capture) begin
            r_addr_q <= pc_in;
            r_cnt    <= 16'h0000;
        end else if (w_cnt_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'h0001;
        end
    end

    // Instruction register and the address it came from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir    <= 16'h0000;
            r_ir_pc <= 16'h0000;
        end else if (w_load_ir) begin
            r_ir    <= mem.mem_rdata;
            r_ir_pc <= r_addr_q;
        end
    end

    assign mem.mem_addr = r_addr_q;
    assign mem.mem_rd   = w_mem_rd;
    assign ld_pc        = w_ld_pc;
    assign pc_mux       = PC_MUX_INC;
    assign ir           = r_ir;
    assign ir_pc        = r_ir_pc;
    assign ir_valid     = w_ir_valid;
    assign busy         = (r_state == RD) || (r_state == DONE);
    assign fetch_err    = w_fetch_err;

endmodule : lc3_fetch_unit
`default_nettype wire

// File: tb/tb_lc3_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_lc3_fetch_unit
//  Brief  : Self-checking bench for lc3_fetch_unit: transaction-level model
//           compared every cycle, plus directed literal expectations.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_lc3_fetch_unit;

    localparam int TMO = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        fetch_req = 1'b0;
    logic        flush     = 1'b0;
    logic [15:0] pc_in     = 16'h0000;
    logic        ld_pc;
    logic [1:0]  pc_mux;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    lc3_fetch_unit_if mem_if ();

    lc3_fetch_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_req (fetch_req),
        .flush     (flush),
        .pc_in     (pc_in),
        .mem       (mem_if.master),
        .ld_pc     (ld_pc),
        .pc_mux    (pc_mux),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: a fetch is "in memory" for some number of cycles,
    // then "delivered" for one cycle. Tracked as plain counters.
    // ------------------------------------------------------------------
    bit          m_in_mem    = 0;   // read outstanding
    bit          m_delivered = 0;   // instruction just landed
    int          m_waited    = 0;   // read cycles already spent on this fetch
    logic [15:0] m_addr      = 0;
    logic [15:0] m_ir        = 0;
    logic [15:0] m_ir_pc     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_mem = 0; m_delivered = 0; m_waited = 0;
            m_addr = 0; m_ir = 0; m_ir_pc = 0;
        end else if (m_in_mem) begin
            if (flush) begin
                m_in_mem = 0;
            end else if (mem_if.mem_ready) begin
                m_ir = mem_if.mem_rdata; m_ir_pc = m_addr;
                m_in_mem = 0; m_delivered = 1;
            end else if (m_waited + 1 == TMO) begin
                m_in_mem = 0;
            end else begin
                m_waited++;
            end
        end else begin
            m_delivered = 0;
            if (fetch_req && !flush) begin
                m_in_mem = 1; m_waited = 0; m_addr = pc_in;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        check("busy",      busy,              m_in_mem || m_delivered);
        check("mem_rd",    mem_if.mem_rd,     m_in_mem && !flush);
        check("ld_pc",     ld_pc,             m_in_mem && !flush && mem_if.mem_ready);
        check("fetch_err", fetch_err,         m_in_mem && !flush && !mem_if.mem_ready && (m_waited + 1 == TMO));
        check("ir_valid",  ir_valid,          m_delivered && !flush);
        check("pc_mux",    pc_mux,            2'b00);
        check("ir",        ir,                m_ir);
        check("ir_pc",     ir_pc,             m_ir_pc);
        if (m_in_mem || !rst_n)
            check("mem_addr", mem_if.mem_addr, m_addr);
    end

    // ------------------------------------------------------------------
    // Stimulus: one tick = one clock cycle; samples at negedge, drives
    // new inputs 1 time unit after posedge. Optional PC+1 register model.
    // ------------------------------------------------------------------
    bit          pc_auto = 0;
    int          cyc;
    logic        s_ld, s_rd, s_valid, s_err, s_busy;
    logic [15:0] s_addr, s_ir, s_irpc;
    int          c_rd, c_ld, c_err, c_valid, err_cyc, valid_cyc[$];
    logic [15:0] valid_pc[$];
    bit          addr_stable;
    logic [15:0] addr_ref;

    task automatic clr_counts();
        c_rd = 0; c_ld = 0; c_err = 0; c_valid = 0; err_cyc = -1; cyc = 0;
        valid_cyc.delete(); valid_pc.delete(); addr_stable = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        s_ld = ld_pc; s_rd = mem_if.mem_rd; s_valid = ir_valid; s_err = fetch_err;
        s_busy = busy; s_addr = mem_if.mem_addr; s_ir = ir; s_irpc = ir_pc;
        if (s_rd) begin
            c_rd++;
            if (s_addr !== addr_ref) addr_stable = 0;
        end
        if (s_ld) c_ld++;
        if (s_err) begin c_err++; err_cyc = cyc; end
        if (s_valid) begin c_valid++; valid_cyc.push_back(cyc); valid_pc.push_back(s_irpc); end
        @(posedge clk);
        #1;
        if (pc_auto && s_ld) pc_in = pc_in + 16'h0001;
        cyc++;
    endtask

    initial begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 16'h0000;
        clr_counts();
        addr_ref = 16'h0000;

        // ---------------- reset ----------------
        tick(); tick();
        check("rst_mem_addr", s_addr, 16'h0000);
        check("rst_busy",     s_busy, 1'b0);
        check("rst_ir",       s_ir,   16'h0000);
        rst_n = 1'b1;
        tick();

        // ---------------- zero-wait fetch ----------------
        clr_counts();
        pc_in = 16'h3000; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h1234; fetch_req = 1'b1;
        tick();                               // cycle 0, request sampled at E0
        fetch_req = 1'b0;
        tick();                               // cycle 1
        check("zw_addr", s_addr, 16'h3000);
        check("zw_ld",   s_ld,   1'b1);
        check("zw_rd",   s_rd,   1'b1);
        tick();                               // cycle 2
        check("zw_valid", s_valid, 1'b1);
        check("zw_ir",    s_ir,    16'h1234);
        check("zw_ir_pc", s_irpc,  16'h3000);
        tick();

        // ---------------- three wait states ----------------
        clr_counts();
        addr_ref = 16'h3100;
        pc_in = 16'h3100; mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 16'hBEEF; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; pc_in = 16'h3155;   // must not disturb mem_addr
        for (int i = 1; i <= 7; i++) begin
            mem_if.mem_ready = (i == 4);
            tick();
        end
        check("ws_rd_cycles", c_rd, 4);
        check("ws_addr_stab", addr_stable, 1'b1);
        check("ws_valid_n",   c_valid, 1);
        check("ws_valid_cyc", (valid_cyc.size() > 0) ? valid_cyc[0] : -1, 5);
        check("ws_ir",        ir, 16'hBEEF);

        // ---------------- back-to-back fetches ----------------
        clr_counts();
        pc_auto = 1; pc_in = 16'h3000; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h5A5A; fetch_req = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i == 6) fetch_req = 1'b0;
            tick();
        end
        pc_auto = 0;
        check("b2b_valid_n", c_valid, 3);
        if (valid_pc.size() == 3) begin
            check("b2b_pc0", valid_pc[0], 16'h3000);
            check("b2b_pc1", valid_pc[1], 16'h3001);
            check("b2b_pc2", valid_pc[2], 16'h3002);
            check("b2b_cyc0", valid_cyc[0], 2);
            check("b2b_cyc1", valid_cyc[1], 4);
            check("b2b_cyc2", valid_cyc[2], 6);
        end
        check("b2b_pc_end", pc_in, 16'h3003);

        // ---------------- timeout ----------------
        clr_counts();
        addr_ref = 16'h4000;
        pc_in = 16'h4000; mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 16'hDEAD; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("to_rd_cycles", c_rd,    4);
        check("to_err_n",     c_err,   1);
        check("to_err_cyc",   err_cyc, 4);
        check("to_ld",        c_ld,    0);
        check("to_ir",        ir,      16'h5A5A);

        // ---------------- flush in RD with mem_ready ----------------
        clr_counts();
        pc_in = 16'h5000; mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 16'h9999; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();                               // first RD cycle, waiting
        flush = 1'b1; mem_if.mem_ready = 1'b1;
        tick();                               // second RD cycle, flushed
        check("fl_ld", s_ld, 1'b0);
        check("fl_rd", s_rd, 1'b0);
        flush = 1'b0; mem_if.mem_ready = 1'b0;
        tick();
        check("fl_idle", s_busy, 1'b0);
        check("fl_ir",   s_ir,   16'h5A5A);

        // ---------------- flush in DONE ----------------
        clr_counts();
        pc_in = 16'h5100; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h7777; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();                               // RD, loads
        flush = 1'b1;
        tick();                               // DONE, flushed
        check("fd_valid", s_valid, 1'b0);
        check("fd_ir",    s_ir,    16'h7777);
        flush = 1'b0; mem_if.mem_ready = 1'b0;
        tick();
        check("fd_idle", s_busy, 1'b0);

        // ---------------- async reset mid-RD ----------------
        pc_in = 16'h6000; fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;                     // now 1 unit into the RD cycle
        #1;
        check("ar_rd_before", mem_if.mem_rd, 1'b1);
        rst_n = 1'b0;
        #1;                                   // still before the next edge
        check("ar_rd",   mem_if.mem_rd, 1'b0);
        check("ar_busy", busy,          1'b0);
        check("ar_ir",   ir,            16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("ar_idle", s_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_lc3_fetch_unit
`default_nettype wire

// File: doc/lc3_fetch_unit.md
# lc3_fetch_unit

Instruction-fetch sequencer for the LC-3 datapath, sitting directly downstream of the program counter register. It reads the current PC, runs a read handshake with instruction memory, loads the returned word into the instruction register, and issues the PC-increment request (load enable plus mux select "PC+1") back to the PC register. It also handles memory wait states, a bounded timeout, and a flush from the control unit.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of cycles spent in RD waiting for mem_ready before aborting; legal range 1..65535.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control unit requests one instruction fetch; level, sampled in IDLE and DONE.
- flush  in  1  abort the in-flight fetch (branch/interrupt redirect); highest priority after reset.
- pc_in  in  16  current PC from the PC register output.
- mem_addr  out  16  instruction memory read address.
- mem_rd  out  1  read request; held until mem_ready, flush or timeout.
- mem_ready  in  1  memory returns valid mem_rdata this cycle.
- mem_rdata  in  16  instruction word.
- ld_pc  out  1  one-cycle load enable to the PC register.
- pc_mux  out  2  PC source select; always 2'b00 (PC+1).
- ir  out  16  instruction register.
- ir_pc  out  16  address the current ir was fetched from.
- ir_valid  out  1  one-cycle pulse: ir/ir_pc hold a freshly fetched instruction.
- busy  out  1  high in RD and DONE.
- fetch_err  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, RD, DONE. Reset state is IDLE.
- IDLE: if fetch_req and !flush, then addr_q <= pc_in, clear the timeout counter, go to RD.
- RD: mem_rd=1, mem_addr=addr_q (stable for the whole request even if pc_in changes). Priority inside RD, highest first:
  - flush: go to IDLE; no ld_pc, ir unchanged.
  - mem_ready: ir <= mem_rdata, ir_pc <= addr_q, ld_pc=1 (combinational, this cycle), go to DONE.
  - counter == TIMEOUT_CYCLES-1: fetch_err=1, go to IDLE; no ld_pc, ir unchanged.
  - otherwise: increment the counter.
- DONE: ir_valid=1 unless flush is high this cycle. If fetch_req and !flush, capture pc_in (already incremented) into addr_q and go to RD (back-to-back fetch). Otherwise go to IDLE.
- mem_rdata is ignored outside RD. mem_ready outside RD has no effect.
- Widths: the counter is 16 bits and does not wrap. The unit does no address arithmetic; wrap from 16'hFFFF to 0 is the PC register's job.

## Timing
- Reset values: all outputs 0. That covers mem_addr, mem_rd, ld_pc, pc_mux, ir, ir_pc, ir_valid, busy and fetch_err; addr_q and the counter are also 0.
- Latency with zero-wait memory:
  - fetch_req sampled at edge E0.
  - RD during cycle 1; mem_ready high, so ld_pc=1 in cycle 1.
  - ir loaded and PC incremented at E1.
  - ir_valid=1 in cycle 2.
- Each memory wait cycle adds exactly one cycle.
- Sustained throughput with back-to-back requests: one instruction per 2 cycles.
- Timeout: with mem_ready held low, fetch_err pulses in the TIMEOUT_CYCLES-th RD cycle, and the unit is back in IDLE the next cycle.
- ld_pc and mem_rd are never high in the same cycle as flush.
- rst_n assertion mid-RD drops mem_rd immediately (asynchronously) and returns to IDLE.

## Structure
- Shared package lc3_pkg:
  - PC_MUX_INC=2'b00, PC_MUX_BUS=2'b01, PC_MUX_JMP=2'b10, shared with the PC register.
  - fetch state enum {IDLE, RD, DONE}.
- Single module. The timeout counter stays inline; no sub-module is warranted.

## Test plan
- Reset, then fetch_req=1 for 1 cycle, pc_in=16'h3000, mem_ready=1 immediately, mem_rdata=16'h1234:
  - mem_addr=16'h3000 in cycle 1 with ld_pc=1, pc_mux=00.
  - ir=16'h1234, ir_pc=16'h3000, ir_valid=1 in cycle 2.
- Three wait states (mem_ready low 3 cycles, then high) -> mem_rd high for 4 cycles, mem_addr constant, ir_valid 5 cycles after the request edge.
- fetch_req held high, zero-wait memory, PC model increments on ld_pc from 16'h3000 -> ir_pc sequence 3000, 3001, 3002, with ir_valid every 2nd cycle.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> exactly 4 cycles of mem_rd, a fetch_err pulse in the 4th cycle, no ld_pc, ir unchanged.
- flush in the 2nd RD cycle with mem_ready also high -> no ld_pc, ir unchanged, IDLE next cycle. Separately, flush in DONE -> ir_valid suppressed.
- rst_n pulled low while in RD with mem_rd=1 -> mem_rd, busy and ir drop to 0 before the next clock edge, state IDLE.
